write_offset_translator: RTL and testbench

Per-thread offset translation for the write-address path. This block is the write-side counterpart of the read-address offsetting stage. It sits at the end of the pipeline, in front of the A/B/I/H memory write ports. It adds the issuing thread's private-data offset to every write address outside High-Mem and I/O, so that shared code writes to per-thread private data. It also owns the per-thread offset table that software programs through High-Mem.

---
 rtl/write_offset_translator_pkg.sv | 30 +++
 rtl/write_offset_translator_if.sv | 32 +++
 rtl/write_offset_translator_thread_counter.sv | 40 ++++
 rtl/write_offset_translator.sv | 157 +++++++++++++++
 tb/tb_write_offset_translator.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/write_offset_translator_pkg.sv
// Shared definitions for the write-address offset translator and its helpers.
// The address-range constants are the default memory map; the top-level
// parameters start from them and a particular instance may override them.
package write_offset_translator_pkg;

  localparam int WORD_WIDTH_DEFAULT          = 36;
  localparam int WRITE_ADDR_WIDTH_DEFAULT    = 12;
  localparam int THREAD_COUNT_DEFAULT        = 8;
  localparam int THREAD_ADDR_WIDTH_DEFAULT   = 3;
  localparam int INITIAL_THREAD_DEFAULT      = 0;

  // High-Mem, I/O and offset-table placement in the write address space
  localparam int OFFSETS_H_ADDR_BASE_DEFAULT = 0;
  localparam int H_WRITE_ADDR_OFFSET_DEFAULT = 0;
  localparam int H_DEPTH_DEFAULT             = 0;
  localparam int IO_ADDR_BASE_DEFAULT        = 0;
  localparam int IO_ADDR_COUNT_DEFAULT       = 0;

  typedef logic [THREAD_ADDR_WIDTH_DEFAULT-1:0] thread_id_t;

  // True when addr lies in [base, base+count-1]; an empty range never matches
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] count);
    logic [31:0] delta;
    delta = addr - base;
    return (addr >= base) && (delta < count);
  endfunction

endpackage

// File: rtl/write_offset_translator_if.sv
// Write-path bus between the pipeline and the translator: raw writes travel
// in, translated writes (tagged with their issuing thread) travel out.
interface write_offset_translator_if
  import write_offset_translator_pkg::*;
#(
  parameter int WORD_WIDTH        = WORD_WIDTH_DEFAULT,
  parameter int WRITE_ADDR_WIDTH  = WRITE_ADDR_WIDTH_DEFAULT,
  parameter int THREAD_ADDR_WIDTH = THREAD_ADDR_WIDTH_DEFAULT
);

  logic                         in_valid;
  logic [WRITE_ADDR_WIDTH-1:0]  in_addr;
  logic [WORD_WIDTH-1:0]        in_data;

  logic                         out_valid;
  logic [WRITE_ADDR_WIDTH-1:0]  out_addr;
  logic [WORD_WIDTH-1:0]        out_data;
  logic [THREAD_ADDR_WIDTH-1:0] out_thread;

  // Upstream/downstream side: issues raw writes and consumes translated ones
  modport master (
    output in_valid, in_addr, in_data,
    input  out_valid, out_addr, out_data, out_thread
  );

  // Translator side: consumes raw writes and issues translated ones
  modport slave (
    input  in_valid, in_addr, in_data,
    output out_valid, out_addr, out_data, out_thread
  );

endinterface

// File: rtl/write_offset_translator_thread_counter.sv
// Round-robin hardware thread counter. Advances every cycle regardless of
// traffic and wraps from THREAD_COUNT-1 back to 0; reusable by any block that
// needs to know which thread owns the current cycle.
module thread_counter #(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic [THREAD_ADDR_WIDTH-1:0] thread_out
);

  localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THREAD  = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_ADDR_WIDTH-1:0] FIRST_THREAD = THREAD_ADDR_WIDTH'(INITIAL_THREAD);
  localparam logic [THREAD_ADDR_WIDTH-1:0] ONE          = THREAD_ADDR_WIDTH'(1);

  logic [THREAD_ADDR_WIDTH-1:0] count_q;
  logic [THREAD_ADDR_WIDTH-1:0] count_d;

  // Next thread: step by one, wrapping after the last thread
  always_comb begin
    count_d = count_q + ONE;
    if (count_q == LAST_THREAD) begin
      count_d = '0;
    end
  end

  // Counter register; reset parks it on the initial thread
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= FIRST_THREAD;
    end else begin
      count_q <= count_d;
    end
  end

  assign thread_out = count_q;

endmodule

// File: rtl/write_offset_translator.sv
// Per-thread offset translation for the write-address path. Writes outside
// High-Mem and I/O get the issuing thread's private-data offset added so
// shared code lands in per-thread data. The per-thread offset table lives in
// flops (so reset can clear it) and is programmed by writes into its window
// inside High-Mem. Two-stage pipeline: stage 1 captures the write, the range
// decision and the thread's offset; stage 2 captures the final address.
module write_offset_translator
  import write_offset_translator_pkg::*;
#(
  parameter int WORD_WIDTH          = WORD_WIDTH_DEFAULT,
  parameter int WRITE_ADDR_WIDTH    = WRITE_ADDR_WIDTH_DEFAULT,
  parameter int OFFSETS_H_ADDR_BASE = OFFSETS_H_ADDR_BASE_DEFAULT,
  parameter int H_WRITE_ADDR_OFFSET = H_WRITE_ADDR_OFFSET_DEFAULT,
  parameter int H_DEPTH             = H_DEPTH_DEFAULT,
  parameter int IO_ADDR_BASE        = IO_ADDR_BASE_DEFAULT,
  parameter int IO_ADDR_COUNT       = IO_ADDR_COUNT_DEFAULT,
  parameter int THREAD_COUNT        = THREAD_COUNT_DEFAULT,
  parameter int THREAD_ADDR_WIDTH   = THREAD_ADDR_WIDTH_DEFAULT,
  parameter int INITIAL_THREAD      = INITIAL_THREAD_DEFAULT
) (
  input logic                      clock,
  input logic                      reset_n,
  write_offset_translator_if.slave bus
);

  localparam int AW  = WRITE_ADDR_WIDTH;
  localparam int WW  = WORD_WIDTH;
  localparam int TAW = THREAD_ADDR_WIDTH;

  // Thread owning the current cycle
  logic [TAW-1:0] thread_now;

  thread_counter #(
    .THREAD_COUNT      (THREAD_COUNT),
    .THREAD_ADDR_WIDTH (TAW),
    .INITIAL_THREAD    (INITIAL_THREAD)
  ) u_thread_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .thread_out (thread_now)
  );

  // Range decode of the incoming raw address
  logic in_hmem;
  logic in_io;
  logic in_table;
  logic raw_now;

  // Offset table
  logic [AW-1:0] offset_q [THREAD_COUNT];
  logic [AW-1:0] offset_d [THREAD_COUNT];

  // Stage 1 registers
  logic           s1_valid_q,  s1_valid_d;
  logic [AW-1:0]  s1_addr_q,   s1_addr_d;
  logic [WW-1:0]  s1_data_q,   s1_data_d;
  logic [TAW-1:0] s1_thread_q, s1_thread_d;
  logic           s1_raw_q,    s1_raw_d;
  logic [AW-1:0]  s1_offset_q, s1_offset_d;

  // Stage 2 registers (drive the outputs directly)
  logic           s2_valid_q,  s2_valid_d;
  logic [AW-1:0]  s2_addr_q,   s2_addr_d;
  logic [WW-1:0]  s2_data_q,   s2_data_d;
  logic [TAW-1:0] s2_thread_q, s2_thread_d;

  // Classify the raw address: High-Mem xor I/O passes untranslated
  always_comb begin
    in_hmem  = in_range(32'(bus.in_addr), H_WRITE_ADDR_OFFSET, H_DEPTH);
    in_io    = in_range(32'(bus.in_addr), IO_ADDR_BASE, IO_ADDR_COUNT);
    in_table = bus.in_valid && in_range(32'(bus.in_addr), OFFSETS_H_ADDR_BASE, THREAD_COUNT);
    raw_now  = in_hmem ^ in_io;
  end

  // Table update: a valid write into the table window loads the addressed entry
  always_comb begin
    offset_d = offset_q;
    for (int i = 0; i < THREAD_COUNT; i++) begin
      if (in_table && (32'(bus.in_addr) == 32'(OFFSETS_H_ADDR_BASE + i))) begin
        offset_d[i] = bus.in_data[AW-1:0];
      end
    end
  end

  // Offset table flops; reset clears every entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        offset_q[i] <= '0;
      end
    end else begin
      offset_q <= offset_d;
    end
  end

  // Stage 1 capture; the offset is read from the current table contents, so
  // an update in this same cycle is only seen by later translations
  always_comb begin
    s1_valid_d  = bus.in_valid;
    s1_addr_d   = bus.in_addr;
    s1_data_d   = bus.in_data;
    s1_thread_d = thread_now;
    s1_raw_d    = raw_now;
    s1_offset_d = offset_q[thread_now];
  end

  // Stage 1 registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      s1_thread_q <= '0;
      s1_raw_q    <= 1'b0;
      s1_offset_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      s1_thread_q <= s1_thread_d;
      s1_raw_q    <= s1_raw_d;
      s1_offset_q <= s1_offset_d;
    end
  end

  // Stage 2: pick raw address or address plus offset, carry out dropped
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_data_d   = s1_data_q;
    s2_thread_d = s1_thread_q;
    s2_addr_d   = s1_addr_q + s1_offset_q;
    if (s1_raw_q) begin
      s2_addr_d = s1_addr_q;
    end
  end

  // Stage 2 registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_data_q   <= '0;
      s2_thread_q <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_addr_q   <= s2_addr_d;
      s2_data_q   <= s2_data_d;
      s2_thread_q <= s2_thread_d;
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_addr   = s2_addr_q;
  assign bus.out_data   = s2_data_q;
  assign bus.out_thread = s2_thread_q;

endmodule

// File: tb/tb_write_offset_translator.sv
// Bench for write_offset_translator. A behavioural model (thread number,
// integer offset table, range checks in plain arithmetic) predicts each
// output record; outputs are sampled on falling edges, two steps after input.
module tb_write_offset_translator;
  import write_offset_translator_pkg::*;

  localparam int WW      = 36;
  localparam int AW      = 12;
  localparam int TC      = 8;
  localparam int TAW     = 3;
  localparam int INIT    = 0;
  localparam int HBASE   = 'h800;
  localparam int HDEPTH  = 'h400;
  localparam int OFFBASE = 'h800;
  localparam int IOBASE  = 'hE00;
  localparam int IOCOUNT = 'h20;
  localparam int MAXSTEPS = 2048;

  localparam int VALID_BIT = AW + WW + TAW;
  localparam int ADDR_LSB  = WW + TAW;

  typedef logic [AW+WW+TAW:0] rec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  write_offset_translator_if #(
    .WORD_WIDTH(WW), .WRITE_ADDR_WIDTH(AW), .THREAD_ADDR_WIDTH(TAW)
  ) bus ();

  write_offset_translator #(
    .WORD_WIDTH(WW), .WRITE_ADDR_WIDTH(AW), .OFFSETS_H_ADDR_BASE(OFFBASE),
    .H_WRITE_ADDR_OFFSET(HBASE), .H_DEPTH(HDEPTH), .IO_ADDR_BASE(IOBASE),
    .IO_ADDR_COUNT(IOCOUNT), .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(TAW),
    .INITIAL_THREAD(INIT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_compared = 0;
  int n_mismatched = 0;
  int step_n = 0;
  rec_t exp_rec [MAXSTEPS];
  rec_t obs_rec [MAXSTEPS];
  int model_off [TC];
  int model_thread = INIT;
  bit release_pending = 1'b0;

  function automatic bit addr_in(input int a, input int base, input int count);
    return (a >= base) && (a < base + count);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TC; i++) model_off[i] = 0;
    model_thread = INIT;
  endtask

  // One cycle: record outputs, drive input, predict its output record
  task automatic apply_stimulus(input bit v, input int a, input logic [WW-1:0] d);
    int t;
    bit raw;
    int xa;
    @(negedge clock);
    if (step_n >= MAXSTEPS) begin
      $display("[TB] FAIL step_budget: used %0d steps, limit %0d", step_n, MAXSTEPS);
      $fatal(1, "[TB] step budget exhausted");
    end
    obs_rec[step_n] = {bus.out_valid, bus.out_addr, bus.out_data, bus.out_thread};
    if (release_pending) begin
      reset_n = 1'b1;
      release_pending = 1'b0;
    end
    bus.in_valid = v;
    bus.in_addr  = AW'(a);
    bus.in_data  = d;
    t   = model_thread;
    raw = addr_in(a, HBASE, HDEPTH) != addr_in(a, IOBASE, IOCOUNT);
    xa  = raw ? a : (a + model_off[t]) % (1 << AW);
    exp_rec[step_n] = {v, AW'(xa), d, TAW'(t)};
    if (v && addr_in(a, OFFBASE, TC)) model_off[a - OFFBASE] = int'(d[AW-1:0]);
    model_thread = (t + 1) % TC;
    step_n++;
  endtask

  task automatic idle(input int k);
    repeat (k) apply_stimulus(1'b0, 0, '0);
  endtask

  task automatic go_to_thread(input int t);
    for (int i = 0; i < TC; i++) begin
      if (model_thread != t) idle(1);
    end
  endtask

  function automatic logic [WW-1:0] rand_data();
    return {4'($urandom), $urandom};
  endfunction

  task automatic test_reset();
    rec_t now_rec;
    int s;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    #2 reset_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      now_rec = {bus.out_valid, bus.out_addr, bus.out_data, bus.out_thread};
      n_compared++;
      if (now_rec !== '0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_outputs: got %h, expected 0", now_rec);
      end
    end
    release_pending = 1'b1;
    s = step_n;
    idle(10);
    idle(2);
    for (int i = s; i < s + 10; i++) begin
      n_compared++;
      if (obs_rec[i+2] !== exp_rec[i]) begin
        n_mismatched++;
        $display("[TB] FAIL idle_model step %0d: got %h, expected %h", i, obs_rec[i+2], exp_rec[i]);
      end
      n_compared++;
      if (obs_rec[i+2] !== rec_t'((i - s) % TC)) begin
        n_mismatched++;
        $display("[TB] FAIL idle_walk step %0d: got %h, expected thread %0d and all else 0",
                 i, obs_rec[i+2], (i - s) % TC);
      end
    end
  endtask

  task automatic test_zero_offset();
    int s;
    logic [WW-1:0] d;
    go_to_thread(3);
    s = step_n;
    d = rand_data();
    apply_stimulus(1'b1, 'h100, d);
    idle(2);
    n_compared++;
    if (obs_rec[s+2] !== exp_rec[s]) begin
      n_mismatched++;
      $display("[TB] FAIL zero_offset_model: got %h, expected %h", obs_rec[s+2], exp_rec[s]);
    end
    n_compared++;
    if (obs_rec[s+2] !== {1'b1, 12'h100, d, 3'd3}) begin
      n_mismatched++;
      $display("[TB] FAIL zero_offset: got %h, expected addr 100 thread 3 valid", obs_rec[s+2]);
    end
  endtask

  task automatic test_offset_program();
    int s, w1, w2, w3, e;
    go_to_thread(0);
    s = step_n;
    apply_stimulus(1'b1, OFFBASE + 5, 36'h40);
    go_to_thread(5);
    w1 = step_n;
    apply_stimulus(1'b1, 'h100, rand_data());
    go_to_thread(5);
    w2 = step_n;
    apply_stimulus(1'b1, IOBASE + 3, rand_data());
    w3 = step_n;
    apply_stimulus(1'b1, 'h900, rand_data());
    e = step_n;
    idle(2);
    for (int i = s; i < e; i++) begin
      n_compared++;
      if (obs_rec[i+2] !== exp_rec[i]) begin
        n_mismatched++;
        $display("[TB] FAIL offset_model step %0d: got %h, expected %h", i, obs_rec[i+2], exp_rec[i]);
      end
    end
    n_compared++;
    if (obs_rec[s+2][ADDR_LSB +: AW] !== AW'(OFFBASE + 5)) begin
      n_mismatched++;
      $display("[TB] FAIL table_write_raw: got %h, expected %h", obs_rec[s+2][ADDR_LSB +: AW], OFFBASE + 5);
    end
    n_compared++;
    if (obs_rec[w1+2][ADDR_LSB +: AW] !== 12'h140) begin
      n_mismatched++;
      $display("[TB] FAIL thread5_offset: got %h, expected 140", obs_rec[w1+2][ADDR_LSB +: AW]);
    end
    n_compared++;
    if (obs_rec[w2+2][ADDR_LSB +: AW] !== AW'(IOBASE + 3)) begin
      n_mismatched++;
      $display("[TB] FAIL io_raw: got %h, expected %h", obs_rec[w2+2][ADDR_LSB +: AW], IOBASE + 3);
    end
    n_compared++;
    if (obs_rec[w3+2][ADDR_LSB +: AW] !== 12'h900) begin
      n_mismatched++;
      $display("[TB] FAIL hmem_raw: got %h, expected 900", obs_rec[w3+2][ADDR_LSB +: AW]);
    end
  endtask

  task automatic test_wrap();
    int w;
    apply_stimulus(1'b1, OFFBASE + 2, 36'hFFF);
    go_to_thread(2);
    w = step_n;
    apply_stimulus(1'b1, 'h002, rand_data());
    idle(2);
    n_compared++;
    if (obs_rec[w+2] !== exp_rec[w] || obs_rec[w+2][ADDR_LSB +: AW] !== 12'h001) begin
      n_mismatched++;
      $display("[TB] FAIL wrap: got %h, expected %h (addr 001)", obs_rec[w+2], exp_rec[w]);
    end
  endtask

  task automatic test_same_cycle();
    int s, w1, w2, e;
    s = step_n;
    apply_stimulus(1'b1, OFFBASE + 4, 36'h008);
    go_to_thread(4);
    apply_stimulus(1'b1, OFFBASE + 4, 36'h020);
    go_to_thread(4);
    w1 = step_n;
    apply_stimulus(1'b1, 'h010, rand_data());
    go_to_thread(3);
    apply_stimulus(1'b1, OFFBASE + 4, 36'h050);
    w2 = step_n;
    apply_stimulus(1'b1, 'h010, rand_data());
    e = step_n;
    idle(2);
    for (int i = s; i < e; i++) begin
      n_compared++;
      if (obs_rec[i+2] !== exp_rec[i]) begin
        n_mismatched++;
        $display("[TB] FAIL update_model step %0d: got %h, expected %h", i, obs_rec[i+2], exp_rec[i]);
      end
    end
    n_compared++;
    if (obs_rec[w1+2][ADDR_LSB +: AW] !== 12'h030) begin
      n_mismatched++;
      $display("[TB] FAIL next_round_offset: got %h, expected 030", obs_rec[w1+2][ADDR_LSB +: AW]);
    end
    n_compared++;
    if (obs_rec[w2+2][ADDR_LSB +: AW] !== 12'h060) begin
      n_mismatched++;
      $display("[TB] FAIL next_cycle_offset: got %h, expected 060", obs_rec[w2+2][ADDR_LSB +: AW]);
    end
  endtask

  task automatic test_random();
    int s, a;
    bit v;
    s = step_n;
    repeat (200) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       a = OFFBASE + int'($urandom_range(0, TC - 1));
        1:       a = HBASE + int'($urandom_range(0, HDEPTH - 1));
        2:       a = IOBASE + int'($urandom_range(0, IOCOUNT - 1));
        default: a = int'($urandom_range(0, (1 << AW) - 1));
      endcase
      apply_stimulus(v, a, rand_data());
    end
    idle(2);
    for (int i = s; i < s + 200; i++) begin
      n_compared++;
      if (obs_rec[i+2] !== exp_rec[i]) begin
        n_mismatched++;
        $display("[TB] FAIL random step %0d: got %h, expected %h", i, obs_rec[i+2], exp_rec[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rec_t now_rec;
    int s, e;
    for (int t = 0; t < TC; t++) apply_stimulus(1'b1, OFFBASE + t, WW'(t * 16 + 1));
    go_to_thread(1);
    apply_stimulus(1'b1, 'h123, rand_data());
    apply_stimulus(1'b1, 'h200, rand_data());
    @(posedge clock);
    #2;
    n_compared++;
    if (bus.out_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL inflight_valid: got %b, expected 1", bus.out_valid);
    end
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    model_reset();
    #1;
    now_rec = {bus.out_valid, bus.out_addr, bus.out_data, bus.out_thread};
    n_compared++;
    if (now_rec !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_immediate: got %h, expected 0", now_rec);
    end
    repeat (3) begin
      @(negedge clock);
      n_compared++;
      if (bus.out_valid !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL midreset_hold: valid %b, expected 0", bus.out_valid);
      end
    end
    release_pending = 1'b1;
    s = step_n;
    idle(8);
    for (int k = 0; k < TC; k++) apply_stimulus(1'b1, 'h100 + k * 3, rand_data());
    e = step_n;
    idle(2);
    for (int i = s; i < e; i++) begin
      n_compared++;
      if (obs_rec[i+2] !== exp_rec[i]) begin
        n_mismatched++;
        $display("[TB] FAIL post_reset_model step %0d: got %h, expected %h", i, obs_rec[i+2], exp_rec[i]);
      end
    end
    for (int k = 0; k < TC; k++) begin
      n_compared++;
      if (obs_rec[s+8+k+2][ADDR_LSB +: AW] !== AW'('h100 + k * 3) ||
          obs_rec[s+8+k+2][VALID_BIT] !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL cleared_table thread %0d: got %h, expected addr %h valid",
                 k, obs_rec[s+8+k+2], 'h100 + k * 3);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_zero_offset();
    test_offset_program();
    test_wrap();
    test_same_cycle();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
